rule_sequencer: RTL and testbench

Upstream stimulus stage for the German coherence `system` model. It drives the 5-bit rule-select input `io_en_a` one rule per clock while running. Three sources are available: round-robin over all rules, replay of a short loaded script, or pseudo-random selection. Simulation and bounded-formal harnesses use it to replay or sweep rule sequences without hand-writing per-cycle stimulus.

---
 rtl/rule_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_rule_sequencer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/rule_sequencer.sv
// rule_sequencer: drives the 5-bit rule-select input of the `system` model,
// one rule per clock while running. Three rule sources:
//   mode 0/3 round-robin over 0..NUM_RULES-1
//   mode 1   replay of a looping script loaded while idle
//   mode 2   pseudo-random (LFSR), only with RULE_SEQ_LFSR_EN defined;
//            without that macro mode 2 falls back to round-robin and no
//            LFSR hardware is built.
// Ports:
//   clock, reset          single clock, synchronous active-high reset
//   io_mode, io_len       source select / run length, sampled on io_start
//   io_start, io_abort    start a run (IDLE only) / cut a run short (RUN only)
//   io_load_valid/rule    script write port, io_load_ready back-pressure
//   io_clear              empty the script (IDLE only, beats a same-cycle load)
//   io_en_a               registered rule select (IDLE_RULE when not running)
//   io_busy, io_done      RUN indication / one-cycle end-of-run pulse
//   io_step_count         rules emitted in the current or last run
// The first rule is loaded into io_en_a on the start edge itself, so
// io_step_count always equals the number of rules that have appeared.
module rule_sequencer #(
    parameter int          NUM_RULES    = 20,
    parameter logic [4:0]  IDLE_RULE    = 5'd31,
    parameter int          SCRIPT_DEPTH = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [1:0]  io_mode,
    input  logic [15:0] io_len,
    input  logic        io_start,
    input  logic        io_abort,
    input  logic        io_load_valid,
    input  logic [4:0]  io_load_rule,
    output logic        io_load_ready,
    input  logic        io_clear,
    output logic [4:0]  io_en_a,
    output logic        io_busy,
    output logic        io_done,
    output logic [15:0] io_step_count
);
    localparam int         AW        = $clog2(SCRIPT_DEPTH);
    localparam int         CW        = AW + 1;
    localparam logic [4:0] LAST_RULE = 5'(NUM_RULES - 1);
    localparam logic [4:0] NR5       = 5'(NUM_RULES);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t         state_q, state_d;
    logic [1:0]     mode_q, mode_d;
    logic [15:0]    len_q, len_d;
    logic [15:0]    step_q, step_d;
    logic [4:0]     en_a_q, en_a_d;
    logic [4:0]     rr_q, rr_d;
    logic [AW-1:0]  rd_q, rd_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [4:0]     script_q [SCRIPT_DEPTH];
    logic [4:0]     script_d [SCRIPT_DEPTH];
`ifdef RULE_SEQ_LFSR_EN
    logic [15:0]    lfsr_q, lfsr_d;
    logic [15:0]    lfsr_nxt;
    logic [4:0]     lfsr_rule;
`endif

    logic           start_ok;
    logic           emit;
    logic [1:0]     src_mode;
    logic [4:0]     src_rr, rr_nxt;
    logic [AW-1:0]  src_rd, rd_nxt;
    logic [4:0]     emit_rule;

    always_comb begin
        io_load_ready = (state_q == S_IDLE) && (cnt_q < CW'(SCRIPT_DEPTH));
        start_ok      = (state_q == S_IDLE) && io_start;

        // On the start edge the pointers are being reset to 0, so the first
        // rule must come from the reset values, not the stale registers.
        src_mode = start_ok ? io_mode : mode_q;
        src_rr   = start_ok ? 5'd0 : rr_q;
        src_rd   = start_ok ? '0 : rd_q;

        rr_nxt = (src_rr == LAST_RULE) ? 5'd0 : src_rr + 5'd1;
        rd_nxt = ((CW'(src_rd) + CW'(1)) == cnt_q) ? '0 : src_rd + AW'(1);
`ifdef RULE_SEQ_LFSR_EN
        lfsr_nxt  = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        // NUM_RULES >= 16 bounds lfsr[4:0] below 2*NUM_RULES: one subtract folds it.
        lfsr_rule = (lfsr_q[4:0] >= NR5) ? lfsr_q[4:0] - NR5 : lfsr_q[4:0];
`endif

        case (src_mode)
            2'd1:    emit_rule = script_q[src_rd];
`ifdef RULE_SEQ_LFSR_EN
            2'd2:    emit_rule = lfsr_rule;
`endif
            default: emit_rule = src_rr;
        endcase

        state_d  = state_q;
        mode_d   = mode_q;
        len_d    = len_q;
        step_d   = step_q;
        en_a_d   = en_a_q;
        rr_d     = rr_q;
        rd_d     = rd_q;
        cnt_d    = cnt_q;
        script_d = script_q;
`ifdef RULE_SEQ_LFSR_EN
        lfsr_d   = lfsr_q;
`endif
        emit     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (io_clear) begin
                    cnt_d = '0;
                end else if (io_load_valid && io_load_ready) begin
                    script_d[cnt_q[AW-1:0]] = io_load_rule;
                    cnt_d = cnt_q + CW'(1);
                end
                if (io_start) begin
                    mode_d = io_mode;
                    len_d  = io_len;
                    step_d = 16'd0;
                    rr_d   = 5'd0;
                    rd_d   = '0;
                    if (io_len == 16'd0 || (io_mode == 2'd1 && cnt_q == '0)) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_RUN;
                        emit    = 1'b1;
                    end
                end
            end
            S_RUN: begin
                // Abort suppresses this cycle's emit; a finished count just ends.
                if (io_abort || step_q == len_q) begin
                    state_d = S_DONE;
                    en_a_d  = IDLE_RULE;
                end else begin
                    emit = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                en_a_d  = IDLE_RULE;
            end
        endcase

        if (emit) begin
            en_a_d = emit_rule;
            step_d = start_ok ? 16'd1 : step_q + 16'd1;
            case (src_mode)
                2'd1:    rd_d = rd_nxt;
`ifdef RULE_SEQ_LFSR_EN
                2'd2:    lfsr_d = lfsr_nxt;
`endif
                default: rr_d = rr_nxt;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            mode_q  <= 2'd0;
            len_q   <= 16'd0;
            step_q  <= 16'd0;
            en_a_q  <= IDLE_RULE;
            rr_q    <= 5'd0;
            rd_q    <= '0;
            cnt_q   <= '0;
            for (int i = 0; i < SCRIPT_DEPTH; i++) script_q[i] <= 5'd0;
`ifdef RULE_SEQ_LFSR_EN
            lfsr_q  <= 16'hACE1;
`endif
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            len_q    <= len_d;
            step_q   <= step_d;
            en_a_q   <= en_a_d;
            rr_q     <= rr_d;
            rd_q     <= rd_d;
            cnt_q    <= cnt_d;
            script_q <= script_d;
`ifdef RULE_SEQ_LFSR_EN
            lfsr_q   <= lfsr_d;
`endif
        end
    end

    assign io_en_a       = en_a_q;
    assign io_busy       = (state_q == S_RUN);
    assign io_done       = (state_q == S_DONE);
    assign io_step_count = step_q;

endmodule

// File: tb/tb_rule_sequencer.sv
// Bench for rule_sequencer: directed steps plus randomized runs, each run
// checked cycle by cycle against a list of expected rules built from the
// source rules (modulo arithmetic, a script queue, a reference LFSR).
module tb_rule_sequencer;
    localparam int NR = 20;

    logic        clock = 1'b0;
    logic        reset;
    logic [1:0]  io_mode;
    logic [15:0] io_len;
    logic        io_start, io_abort, io_load_valid, io_clear;
    logic [4:0]  io_load_rule;
    logic        io_load_ready, io_busy, io_done;
    logic [4:0]  io_en_a;
    logic [15:0] io_step_count;

    int pass_cnt = 0;
    int fail_cnt = 0;
    int total    = 0;

    logic [4:0] scr[$];            // model of the script contents
`ifdef RULE_SEQ_LFSR_EN
    logic [15:0] lfsr_m;
`endif

    rule_sequencer dut (
        .clock(clock), .reset(reset), .io_mode(io_mode), .io_len(io_len),
        .io_start(io_start), .io_abort(io_abort), .io_load_valid(io_load_valid),
        .io_load_rule(io_load_rule), .io_load_ready(io_load_ready),
        .io_clear(io_clear), .io_en_a(io_en_a), .io_busy(io_busy),
        .io_done(io_done), .io_step_count(io_step_count)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        scr.delete();
`ifdef RULE_SEQ_LFSR_EN
        lfsr_m = 16'hACE1;
`endif
    endtask

    task automatic load(input logic [4:0] r);
        bit exp_rdy;
        exp_rdy = (scr.size() < 8);
        check("load_ready", 32'(io_load_ready), 32'(exp_rdy));
        io_load_valid = 1'b1;
        io_load_rule  = r;
        tick();
        io_load_valid = 1'b0;
        if (exp_rdy) scr.push_back(r);
    endtask

    task automatic clear_script();
        io_clear = 1'b1;
        tick();
        io_clear = 1'b0;
        scr.delete();
    endtask

    // One run: start, then check every cycle until the DONE pulse is over.
    // ab > 0 raises abort during the ab-th run cycle (that cycle's rule is
    // still counted; the following slot is suppressed).
    task automatic run(input logic [1:0] m, input int l, input int ab, input bit chk_range);
        logic [4:0] exp_q[$];
        int  n_emit;
        bit  zero;
        zero   = (l == 0) || (m == 2'd1 && scr.size() == 0);
        n_emit = zero ? 0 : ((ab > 0) ? ab : l);
        for (int i = 0; i < n_emit; i++) begin
            case (m)
                2'd1: exp_q.push_back(scr[i % scr.size()]);
`ifdef RULE_SEQ_LFSR_EN
                2'd2: begin
                    exp_q.push_back(5'(lfsr_m[4:0] % NR));
                    lfsr_m = {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
                end
`endif
                default: exp_q.push_back(5'(i % NR));
            endcase
        end
        io_mode  = m;
        io_len   = 16'(l);
        io_start = 1'b1;
        tick();
        io_start = 1'b0;
        for (int c = 1; c <= n_emit; c++) begin
            check($sformatf("en_a[m%0d c%0d]", m, c), 32'(io_en_a), 32'(exp_q[c-1]));
            check("busy_run", 32'(io_busy), 32'd1);
            check("step_run", 32'(io_step_count), 32'(c));
            if (chk_range) check("lfsr_range", 32'(io_en_a < 5'(NR)), 32'd1);
            if (c == ab) io_abort = 1'b1;
            tick();
            io_abort = 1'b0;
        end
        check("done_pulse", 32'(io_done), 32'd1);
        check("en_a_done", 32'(io_en_a), 32'd31);
        check("busy_done", 32'(io_busy), 32'd0);
        check("step_final", 32'(io_step_count), 32'(n_emit));
        tick();
        check("done_drop", 32'(io_done), 32'd0);
        check("step_hold", 32'(io_step_count), 32'(n_emit));
        check("ready_idle", 32'(io_load_ready), 32'(scr.size() < 8));
    endtask

    initial begin
        int n, ab, l;
        reset = 1'b1; io_mode = 2'd0; io_len = 16'd0; io_start = 1'b0;
        io_abort = 1'b0; io_load_valid = 1'b0; io_load_rule = 5'd0; io_clear = 1'b0;
        tick();
        do_reset();

        check("rst_en_a", 32'(io_en_a), 32'd31);
        check("rst_busy", 32'(io_busy), 32'd0);
        check("rst_done", 32'(io_done), 32'd0);
        check("rst_step", 32'(io_step_count), 32'd0);
        check("rst_ready", 32'(io_load_ready), 32'd1);

        // Round-robin wrap past NUM_RULES-1.
        run(2'd0, 22, 0, 1'b0);

        // Short looping script.
        load(5'd9); load(5'd3); load(5'd31);
        check("ready_cnt3", 32'(io_load_ready), 32'd1);
        run(2'd1, 7, 0, 1'b0);

        // Fill to depth, ninth load must be dropped.
        for (int i = 0; i < 5; i++) load(5'($urandom_range(0, 31)));
        check("ready_full", 32'(io_load_ready), 32'd0);
        load(5'd17);
        check("scr_size", 32'(scr.size()), 32'd8);
        run(2'd1, 19, 0, 1'b0);

        // Clear beats a simultaneous load; empty script ends immediately.
        io_clear = 1'b1; io_load_valid = 1'b1; io_load_rule = 5'd7;
        tick();
        io_clear = 1'b0; io_load_valid = 1'b0;
        scr.delete();
        run(2'd1, 5, 0, 1'b0);
        run(2'd0, 0, 0, 1'b0);

        // Abort after three rules.
        run(2'd0, 10, 3, 1'b0);

        // Mode 2 straight from reset (LFSR seed, or round-robin fallback).
        do_reset();
`ifdef RULE_SEQ_LFSR_EN
        run(2'd2, 3, 0, 1'b1);
        run(2'd2, 25, 0, 1'b1);
`else
        run(2'd2, 3, 0, 1'b0);
        run(2'd3, 25, 0, 1'b0);
`endif

        // Reset in the fifth run cycle, then an immediate restart.
        io_mode = 2'd0; io_len = 16'd50; io_start = 1'b1;
        tick();
        io_start = 1'b0;
        for (int c = 1; c < 5; c++) tick();
        do_reset();
        check("mid_rst_en_a", 32'(io_en_a), 32'd31);
        check("mid_rst_busy", 32'(io_busy), 32'd0);
        check("mid_rst_step", 32'(io_step_count), 32'd0);
        check("mid_rst_done", 32'(io_done), 32'd0);
        run(2'd0, 4, 0, 1'b0);

        // Randomized runs over all modes, script sizes, lengths and aborts.
        for (int it = 0; it < 12; it++) begin
            clear_script();
            n = $urandom_range(0, 9);
            for (int k = 0; k < n; k++) load(5'($urandom_range(0, 31)));
            l  = $urandom_range(1, 30);
            ab = ($urandom_range(0, 1) == 1) ? $urandom_range(1, l) : 0;
            run(2'($urandom_range(0, 3)), l, ab, 1'b0);
        end

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
